// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one unrolled CORDIC rotation pipeline between
// NUM_REQ phase requesters. Each result comes back quadrant-unfolded and tagged.
module cordic_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int ANGLE_WIDTH  = 16,
    parameter int PHASE_WIDTH  = 18,
    parameter int PIPE_LATENCY = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*PHASE_WIDTH-1:0]         req_phase,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [DATA_WIDTH:0]                    cfg_amp,
    input  logic                                   flush,
    output logic                                   res_valid,
    output logic [$clog2(NUM_REQ)-1:0]             res_id,
    output logic [DATA_WIDTH:0]                    res_cos,
    output logic [DATA_WIDTH:0]                    res_sin,
    output logic [$clog2(PIPE_LATENCY+2):0]        in_flight
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int RW    = DATA_WIDTH + 1;
    localparam int FRAC  = 6;
    localparam int XW    = RW + 2 + FRAC;
    localparam int ZW    = ANGLE_WIDTH + 2;
    localparam int FW    = $clog2(PIPE_LATENCY+2) + 1;
    localparam int KSH   = 31 - ANGLE_WIDTH;
    localparam int PRODW = PHASE_WIDTH - 2 + ANGLE_WIDTH;
    localparam logic [63:0] HALF_PI_Q30 = 64'd1686629713;
    localparam logic [63:0] K_CONST = (HALF_PI_Q30 + (64'd1 << (KSH - 1))) >> KSH;
    localparam logic signed [XW-1:0] X_MAX = XW'((1 << DATA_WIDTH) - 1);
    localparam logic signed [XW-1:0] X_MIN = ~X_MAX;
    localparam logic [RW-1:0] R_MIN = {1'b1, {DATA_WIDTH{1'b0}}};
    localparam logic [RW-1:0] R_MAX = {1'b0, {DATA_WIDTH{1'b1}}};

    // atan(2^-i) scaled by 2^30; below 2^-11 atan(x) equals x to this precision.
    function automatic logic [63:0] atan_q30(input int i);
        case (i)
            0:  return 64'd843314857;
            1:  return 64'd497837829;
            2:  return 64'd263043837;
            3:  return 64'd133525159;
            4:  return 64'd67021687;
            5:  return 64'd33543516;
            6:  return 64'd16775851;
            7:  return 64'd8388437;
            8:  return 64'd4194283;
            9:  return 64'd2097149;
            10: return 64'd1048576;
            11: return 64'd524288;
            default: return (i < 31) ? (64'd1 << (30 - i)) : 64'd0;
        endcase
    endfunction

    function automatic logic [ZW-1:0] atan_z(input int i);
        return ZW'(atan_q30(i) >> KSH);
    endfunction

    function automatic logic [RW-1:0] sat_rw(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] t;
        t = v >>> FRAC;
        if (t > X_MAX)      return R_MAX;
        else if (t < X_MIN) return R_MIN;
        else                return t[RW-1:0];
    endfunction

    function automatic logic [RW-1:0] neg_sat(input logic [RW-1:0] v);
        return (v == R_MIN) ? R_MAX : -v;
    endfunction

    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         grant_id;
    logic                   grant_any;
    logic [PHASE_WIDTH-1:0] phase_sel;
    logic [PRODW-1:0]       prod;
    logic [ANGLE_WIDTH-1:0] theta;

    // Search from the pointer upward with wrap; flush and reset suppress the grant.
    always_comb begin
        int  idx;
        logic found;
        req_ready = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
        if (found && !flush && !rst) begin
            req_ready[grant_id] = 1'b1;
            grant_any           = 1'b1;
        end
    end

    assign phase_sel = req_phase[grant_id*PHASE_WIDTH +: PHASE_WIDTH];
    assign prod      = PRODW'(phase_sel[PHASE_WIDTH-3:0]) * PRODW'(K_CONST);
    assign theta     = ANGLE_WIDTH'(prod >> (PHASE_WIDTH - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
        end
    end

    // Index 0 is the issue register; index s+1 is the output of rotator s.
    logic signed [XW-1:0] xs [0:PIPE_LATENCY];
    logic signed [XW-1:0] ys [0:PIPE_LATENCY];
    logic [ZW-1:0]        zs [0:PIPE_LATENCY];
    logic                 tv [0:PIPE_LATENCY];
    logic [IDW-1:0]       tid [0:PIPE_LATENCY];
    logic [1:0]           tq [0:PIPE_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= PIPE_LATENCY; s++) begin
                xs[s]  <= '0;
                ys[s]  <= '0;
                zs[s]  <= '0;
                tv[s]  <= 1'b0;
                tid[s] <= '0;
                tq[s]  <= '0;
            end
        end else begin
            tv[0] <= grant_any;
            if (grant_any) begin
                xs[0]  <= XW'($signed(cfg_amp)) <<< FRAC;
                ys[0]  <= '0;
                zs[0]  <= {2'b00, theta};
                tid[0] <= grant_id;
                tq[0]  <= phase_sel[PHASE_WIDTH-1 -: 2];
            end
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                tv[s+1]  <= tv[s] & ~flush;
                tid[s+1] <= tid[s];
                tq[s+1]  <= tq[s];
                if (zs[s][ZW-1]) begin
                    xs[s+1] <= xs[s] + (ys[s] >>> s);
                    ys[s+1] <= ys[s] - (xs[s] >>> s);
                    zs[s+1] <= zs[s] + atan_z(s);
                end else begin
                    xs[s+1] <= xs[s] - (ys[s] >>> s);
                    ys[s+1] <= ys[s] + (xs[s] >>> s);
                    zs[s+1] <= zs[s] - atan_z(s);
                end
            end
        end
    end

    logic [RW-1:0] xo;
    logic [RW-1:0] yo;
    assign xo = sat_rw(xs[PIPE_LATENCY]);
    assign yo = sat_rw(ys[PIPE_LATENCY]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_cos   <= '0;
            res_sin   <= '0;
        end else begin
            res_valid <= tv[PIPE_LATENCY] & ~flush;
            if (tv[PIPE_LATENCY]) begin
                res_id <= tid[PIPE_LATENCY];
                case (tq[PIPE_LATENCY])
                    2'd0:    begin res_cos <= xo;          res_sin <= yo;          end
                    2'd1:    begin res_cos <= neg_sat(yo); res_sin <= xo;          end
                    2'd2:    begin res_cos <= neg_sat(xo); res_sin <= neg_sat(yo); end
                    default: begin res_cos <= yo;          res_sin <= neg_sat(xo); end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else if (grant_any && !res_valid) begin
            in_flight <= in_flight + FW'(1);
        end else if (!grant_any && res_valid) begin
            in_flight <= in_flight - FW'(1);
        end
    end
endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed and random bench for cordic_scheduler with a real-arithmetic
// reference model (round-robin search, cos/sin scaled by CORDIC gain).
module tb_cordic_scheduler;
    localparam int NR  = 4;
    localparam int DW  = 12;
    localparam int PW  = 18;
    localparam int LAT = 18;
    localparam real PI = 3.14159265358979;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*PW-1:0] req_phase = '0;
    logic [NR-1:0]   req_ready;
    logic [DW:0]     cfg_amp = '0;
    logic            flush = 1'b0;
    logic            res_valid;
    logic [1:0]      res_id;
    logic [DW:0]     res_cos;
    logic [DW:0]     res_sin;
    logic [5:0]      in_flight;

    cordic_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_phase(req_phase),
        .req_ready(req_ready), .cfg_amp(cfg_amp), .flush(flush),
        .res_valid(res_valid), .res_id(res_id), .res_cos(res_cos),
        .res_sin(res_sin), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int c; int s; int cyc; } exp_t;
    exp_t exp_q[$];
    int   gseq[$];
    int   gcount[NR];
    int   n_cmp = 0, n_err = 0, n_res = 0, cyc = 0, peak = 0, mptr = 0;
    int   last_id = 0, last_cos = 0, last_sin = 0;
    real  gain = 1.0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int expv, input int tol);
        n_cmp++;
        assert (obs >= expv - tol && obs <= expv + tol) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d+-%0d", tag, obs, expv, tol);
        end
    endtask

    function automatic int ref_val(input int amp, input int phase, input bit want_sin);
        real a, v;
        int r;
        a = 2.0 * PI * real'(phase) / 262144.0;
        v = real'(amp) * gain * (want_sin ? $sin(a) : $cos(a));
        r = int'(v);
        if (r > 4095) r = 4095;
        if (r < -4096) r = -4096;
        return r;
    endfunction

    // Reference model and result scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : mon
        int   er;
        int   idx;
        int   ph;
        int   amp;
        exp_t e;
        if (rst) begin
            check("rst_req_ready", int'(req_ready), 0);
            check("rst_res_valid", int'(res_valid), 0);
            exp_q.delete();
            mptr = 0;
        end else begin
            er = -1;
            if (!flush) begin
                for (int i = 0; i < NR; i++) begin
                    idx = (mptr + i) % NR;
                    if (er < 0 && req_valid[idx]) er = idx;
                end
            end
            check("req_ready", int'(req_ready), (er >= 0) ? (1 << er) : 0);
            check("in_flight", int'(in_flight), exp_q.size());
            if (int'(in_flight) > peak) peak = int'(in_flight);
            if (res_valid) begin
                n_res++;
                check("res_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    last_id  = int'(res_id);
                    last_cos = int'($signed(res_cos));
                    last_sin = int'($signed(res_sin));
                    check("res_id", last_id, e.id);
                    check("latency", cyc - e.cyc, LAT);
                    check_tol("res_cos", last_cos, e.c, 4);
                    check_tol("res_sin", last_sin, e.s, 4);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (er >= 0) begin
                ph  = int'(req_phase[er*PW +: PW]);
                amp = int'($signed(cfg_amp));
                e.id  = er;
                e.c   = ref_val(amp, ph, 1'b0);
                e.s   = ref_val(amp, ph, 1'b1);
                e.cyc = cyc;
                exp_q.push_back(e);
                mptr = (er + 1) % NR;
                gcount[er]++;
                gseq.push_back(er);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req_one(input int k, input int phase, input int amp);
        req_valid = '0;
        req_phase[k*PW +: PW] = PW'(phase);
        cfg_amp = (DW+1)'(amp);
        req_valid[k] = 1'b1;
        tick(1);
        req_valid = '0;
    endtask

    task automatic randomize_inputs(input int amax);
        for (int k = 0; k < NR; k++) req_phase[k*PW +: PW] = PW'($urandom_range(0, 262143));
        cfg_amp = (DW+1)'(int'($urandom_range(0, 2*amax)) - amax);
    endtask

    initial begin
        int n0;
        int ph_tab[3];
        int ec_tab[3];
        int es_tab[3];
        ph_tab = '{32'h10000, 32'h20000, 32'h30000};
        ec_tab = '{0, -3294, 0};
        es_tab = '{3294, 0, -3294};
        for (int i = 0; i < 16; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        tick(3);
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_res_id", int'(res_id), 0);
        check("reset_res_cos", int'(res_cos), 0);
        check("reset_res_sin", int'(res_sin), 0);
        check("reset_in_flight", int'(in_flight), 0);
        check("reset_req_ready", int'(req_ready), 0);
        rst = 1'b0;
        tick(2);

        // Single request, phase 0.
        n0 = n_res;
        req_one(0, 0, 2000);
        tick(25);
        check("t1_count", n_res - n0, 1);
        check("t1_id", last_id, 0);
        check_tol("t1_cos", last_cos, 3294, 4);
        check_tol("t1_sin", last_sin, 0, 4);

        // Quadrant unfolding from requester 1.
        for (int i = 0; i < 3; i++) begin
            req_one(1, ph_tab[i], 2000);
            tick(25);
            check("quad_id", last_id, 1);
            check_tol("quad_cos", last_cos, ec_tab[i], 4);
            check_tol("quad_sin", last_sin, es_tab[i], 4);
        end

        // Bring the pointer back to 0, then saturate the arbiter for 12 cycles.
        req_one(3, 0, 100);
        tick(25);
        gseq.delete();
        for (int k = 0; k < NR; k++) gcount[k] = 0;
        peak = 0;
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            randomize_inputs(2400);
            tick(1);
        end
        req_valid = '0;
        tick(25);
        check("rr_peak", peak, 12);
        check("rr_grants", gseq.size(), 12);
        for (int k = 0; k < NR; k++) check("rr_count", gcount[k], 3);
        for (int i = 0; i < 12 && i < gseq.size(); i++) check("rr_order", gseq[i], i % NR);

        // Pointer to 1, then only requesters 0 and 2 valid.
        req_one(0, 5000, 1500);
        tick(25);
        gseq.delete();
        req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(2400);
            tick(1);
        end
        req_valid = '0;
        tick(25);
        check("sparse_grants", gseq.size(), 3);
        if (gseq.size() == 3) begin
            check("sparse_g0", gseq[0], 2);
            check("sparse_g1", gseq[1], 0);
            check("sparse_g2", gseq[2], 2);
        end

        // Flush six cycles after the first of five grants.
        n0 = n_res;
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            randomize_inputs(2400);
            tick(1);
        end
        req_valid = '0;
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_in_flight", int'(in_flight), 0);
        tick(25);
        check("flush_no_results", n_res - n0, 0);
        req_one(2, 20000, 1800);
        tick(25);
        check("post_flush_count", n_res - n0, 1);
        check("post_flush_id", last_id, 2);

        // Negation saturation.
        req_one(0, 32'h20000, -4096);
        tick(25);
        check("sat_cos", last_cos, 4095);
        check_tol("sat_sin", last_sin, 0, 4);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 80; i++) begin
            req_valid = NR'($urandom_range(0, 15));
            randomize_inputs(2400);
            flush = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        req_valid = '0;
        flush = 1'b0;
        tick(25);
        check("random_drained", exp_q.size(), 0);

        // Reset in the middle of a stream.
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            randomize_inputs(2400);
            tick(1);
        end
        req_valid = '0;
        tick(3);
        rst = 1'b1;
        #1;
        check("mid_rst_res_valid", int'(res_valid), 0);
        check("mid_rst_res_id", int'(res_id), 0);
        check("mid_rst_res_cos", int'(res_cos), 0);
        check("mid_rst_res_sin", int'(res_sin), 0);
        check("mid_rst_in_flight", int'(in_flight), 0);
        tick(2);
        rst = 1'b0;
        n0 = n_res;
        tick(30);
        check("no_stale_results", n_res - n0, 0);
        check("post_rst_in_flight", int'(in_flight), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
